rf_wport_arbiter: RTL and testbench
===================================

Name: rf_wport_arbiter

Overview:
Shares the single register-file write port between two sources. Source 0 is the pipeline MEM/WB stage; it has no backpressure and normally wins. Source 1 is a multi-cycle unit (mul/div) with a valid/ready handshake; its result is held in a one-entry buffer until a free port cycle is found. A starvation counter guarantees forward progress by freezing the pipeline for one cycle when the buffer has waited MAX_WAIT cycles. The block sits between MEM/WB, the multi-cycle unit and the register-file write inputs (we, addr, data), and exports buffer occupancy to the ID hazard logic.

Parameters:
DATA_W, 32, write data width
ADDR_W, 5, register address width
MAX_WAIT, 4, number of consecutive blocked cycles before a forced grant; legal range 1..15

Ports:
clk  in  1  clock
rst  in  1  reset
pipe_we  in  1  pipeline writeback enable
pipe_addr  in  ADDR_W  pipeline destination register
pipe_data  in  DATA_W  pipeline writeback data
mc_valid  in  1  multi-cycle result valid
mc_ready  out  1  buffer can accept a result
mc_addr  in  ADDR_W  multi-cycle destination register
mc_data  in  DATA_W  multi-cycle result
pipe_stall  out  1  freeze the pipeline this cycle; MEM/WB holds and re-presents its write
busy_valid  out  1  buffer holds a pending write
busy_addr  out  ADDR_W  destination register of the pending write
rf_we  out  1  register-file write enable
rf_addr  out  ADDR_W  register-file write address
rf_data  out  DATA_W  register-file write data

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- On reset: state=IDLE, buffer empty, wait_cnt=0, pipe_stall=0, busy_valid=0, busy_addr=0, mc_ready=1.
- mc_ready = (state==IDLE). A handshake occurs when mc_valid and mc_ready are both 1 on a clock edge.
- rf_* outputs are combinational from the current inputs and registered state.
  - If no grant is made: rf_we=0, rf_addr=0, rf_data=0.
  - Pipeline path has zero latency (same cycle as pipe_we).
- IDLE:
  - Handshake with mc_addr!=0: capture addr/data, go to WAIT, wait_cnt=0.
  - Handshake with mc_addr==0: result discarded; stay in IDLE.
  - Pipe write passes through: rf_we=pipe_we, rf_addr=pipe_addr, rf_data=pipe_data.
- WAIT:
  - If pipe_we=0: grant the buffer (rf_we=1, buffer addr/data), clear the buffer, go to IDLE.
  - If pipe_we=1: pipe write passes through and wait_cnt increments.
  - If wait_cnt==MAX_WAIT-1 while pipe_we=1: go to FORCE. pipe_stall is registered and goes high on the next cycle.
- FORCE (exactly one cycle):
  - pipe_stall=1; the buffer is granted; pipe_we is ignored, with no write and no loss because the pipeline holds.
  - Then go to IDLE and drop pipe_stall.
- Minimum multi-cycle latency is 1 cycle from handshake to rf_we. Maximum is MAX_WAIT+1 cycles.
- busy_valid=1 in WAIT and FORCE. busy_addr=buffered address in those states, else 0.
  - ID stalls any instruction that reads or writes busy_addr while busy_valid=1, which excludes WAW and RAW ordering hazards.
- pipe_addr==0 writes are passed through unchanged; the register file ignores them.
- No new handshake can occur in WAIT or FORCE. A buffer freed in cycle N accepts a new result at edge N+1 at the earliest.
- Reset mid-operation: the buffered result is dropped; the multi-cycle unit is reset by the same rst.
- wait_cnt is 4 bits wide and saturates; it never wraps.

Decomposition:
- Shared defines (existing defines file): WriteEnable, RstEnable, RegAddrBus, RegBus widths, plus a new state encoding RFA_IDLE/RFA_WAIT/RFA_FORCE (2 bits).
- Single module, no sub-module. The buffer is three registers (valid, addr, data) inline.

Test Plan:
- Reset, then mc_valid=1, mc_addr=5, mc_data=0xDEADBEEF, pipe_we=0 -> mc_ready=1 at the edge; next cycle rf_we=1, rf_addr=5, rf_data=0xDEADBEEF, busy_valid=1, busy_addr=5; the following cycle is IDLE and busy_valid=0.
- Capture mc (addr 7, 0x1) while pipe_we=1 (addr 3, 0xAA) continuously, MAX_WAIT=4 -> 4 cycles of pipe writes to r3, mc_ready=0 throughout; the next cycle has pipe_stall=1 and rf addr=7 data=0x1, and no r3 write that cycle; the cycle after, pipe_stall=0 and the r3 write resumes.
- Buffer full, pipe_we=1 for 2 cycles then 0 -> buffer granted in the pipe_we=0 cycle; pipe_stall never asserts; wait_cnt is cleared.
- mc_addr=0 handshake -> no rf_we, state stays IDLE, mc_ready stays 1, busy_valid stays 0.
- rst=1 in the cycle after capture (WAIT) -> next cycle busy_valid=0, rf_we=0, pipe_stall=0, mc_ready=1; the buffered value is never written.
- Back-to-back mc_valid held high with pipe idle -> accepts every second cycle (IDLE/WAIT alternation); each result is written exactly once, in order.

Source files
------------

// File: rtl/rf_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: enable levels,
// bus widths, arbiter state encoding and the wait-counter helper.
package rf_wport_arbiter_pkg;

  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;

  localparam int REG_ADDR_W = 5;
  localparam int REG_W      = 32;

  // Wide enough for the largest legal MAX_WAIT (15).
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    RFA_IDLE  = 2'd0,
    RFA_WAIT  = 2'd1,
    RFA_FORCE = 2'd2
  } rfa_state_t;

  // Saturating increment: the blocked-cycle count must never wrap back to 0.
  function automatic logic [WAIT_CNT_W-1:0] wait_cnt_inc(input logic [WAIT_CNT_W-1:0] v);
    return (v == {WAIT_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rf_wport_arbiter_if.sv
// Signal bundle between MEM/WB, the multi-cycle unit, the ID hazard logic and
// the register-file write port. The arbiter uses the slave side; whatever
// drives the sources and consumes the write port uses the master side.
interface rf_wport_arbiter_if
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DATA_W = REG_W,
  parameter int ADDR_W = REG_ADDR_W
);

  // pipeline writeback source (no backpressure)
  logic              pipe_we;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              pipe_stall;

  // multi-cycle unit source (valid/ready)
  logic              mc_valid;
  logic              mc_ready;
  logic [ADDR_W-1:0] mc_addr;
  logic [DATA_W-1:0] mc_data;

  // pending-write visibility for ID hazard detection
  logic              busy_valid;
  logic [ADDR_W-1:0] busy_addr;

  // register-file write port
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_data;

  modport slave (
    input  pipe_we, pipe_addr, pipe_data,
    input  mc_valid, mc_addr, mc_data,
    output mc_ready, pipe_stall,
    output busy_valid, busy_addr,
    output rf_we, rf_addr, rf_data
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data,
    output mc_valid, mc_addr, mc_data,
    input  mc_ready, pipe_stall,
    input  busy_valid, busy_addr,
    input  rf_we, rf_addr, rf_data
  );

endinterface

// File: rtl/rf_wport_arbiter.sv
// Register-file write-port arbiter. The pipeline normally owns the port; a
// multi-cycle result waits in a one-entry buffer for a free cycle, and after
// MAX_WAIT consecutive blocked cycles the pipeline is frozen for one cycle so
// the buffered result can be written.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RFA_IDLE  | buffer empty, mc_ready=1, pipeline owns the write port
// RFA_WAIT  | buffer full, written on the first cycle with pipe_we=0
// RFA_FORCE | pipe_stall=1 for one cycle, buffer written unconditionally
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DATA_W   = REG_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int MAX_WAIT = 4
) (
  input logic               clk,
  input logic               rst,
  rf_wport_arbiter_if.slave bus
);

  // Count value on which one more blocked cycle triggers the forced grant.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

  rfa_state_t              state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    stall_q, stall_d;

  logic                    buf_valid_q;
  logic [ADDR_W-1:0]       buf_addr_q;
  logic [DATA_W-1:0]       buf_data_q;
  logic                    buf_load;
  logic                    buf_clear;

  logic                    rf_we_c;
  logic [ADDR_W-1:0]       rf_addr_c;
  logic [DATA_W-1:0]       rf_data_c;

  // State, wait counter and the registered stall flag.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= RFA_IDLE;
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
    end
  end

  // One-entry result buffer; addr/data are zeroed when released so busy_addr
  // reads 0 whenever nothing is pending.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else if (buf_load) begin
      buf_valid_q <= 1'b1;
      buf_addr_q  <= bus.mc_addr;
      buf_data_q  <= bus.mc_data;
    end else if (buf_clear) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end
  end

  // Next-state, buffer control and write-port mux.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    stall_d    = 1'b0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    rf_we_c    = WRITE_DISABLE;
    rf_addr_c  = '0;
    rf_data_c  = '0;

    case (state_q)
      RFA_IDLE: begin
        wait_cnt_d = '0;
        if (bus.pipe_we == WRITE_ENABLE) begin
          rf_we_c   = WRITE_ENABLE;
          rf_addr_c = bus.pipe_addr;
          rf_data_c = bus.pipe_data;
        end
        // A result for r0 would be ignored by the register file anyway, so it
        // is accepted and dropped rather than occupying the buffer.
        if (bus.mc_valid && (bus.mc_addr != '0)) begin
          buf_load = 1'b1;
          state_d  = RFA_WAIT;
        end
      end

      RFA_WAIT: begin
        if (bus.pipe_we == WRITE_ENABLE) begin
          rf_we_c    = WRITE_ENABLE;
          rf_addr_c  = bus.pipe_addr;
          rf_data_c  = bus.pipe_data;
          wait_cnt_d = wait_cnt_inc(wait_cnt_q);
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = RFA_FORCE;
            stall_d = 1'b1;
          end
        end else begin
          rf_we_c    = WRITE_ENABLE;
          rf_addr_c  = buf_addr_q;
          rf_data_c  = buf_data_q;
          buf_clear  = 1'b1;
          wait_cnt_d = '0;
          state_d    = RFA_IDLE;
        end
      end

      RFA_FORCE: begin
        // Pipeline is frozen and re-presents its write next cycle, so its
        // current pipe_we is deliberately not looked at.
        rf_we_c    = WRITE_ENABLE;
        rf_addr_c  = buf_addr_q;
        rf_data_c  = buf_data_q;
        buf_clear  = 1'b1;
        wait_cnt_d = '0;
        state_d    = RFA_IDLE;
      end

      default: begin
        buf_clear  = 1'b1;
        wait_cnt_d = '0;
        state_d    = RFA_IDLE;
      end
    endcase
  end

  assign bus.mc_ready   = (state_q == RFA_IDLE);
  assign bus.pipe_stall = stall_q;
  assign bus.busy_valid = buf_valid_q;
  assign bus.busy_addr  = buf_valid_q ? buf_addr_q : '0;
  assign bus.rf_we      = rf_we_c;
  assign bus.rf_addr    = rf_addr_c;
  assign bus.rf_data    = rf_data_c;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// queue-based model of the pending multi-cycle result.
module tb_rf_wport_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int MAX_WAIT = 4;

  logic clk;
  logic rst;

  rf_wport_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_wport_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t pend_q[$];     // results accepted but not yet written (at most one)
  int   m_blocked;     // cycles the pending result lost the port to the pipe
  bit   m_stall;       // this cycle is the forced, pipeline-frozen cycle
  bit   m_ok = 0;      // model is synchronised once a reset edge has been seen

  always @(posedge clk) begin
    if (rst) begin
      pend_q.delete();
      m_blocked <= 0;
      m_stall   <= 0;
      m_ok      <= 1;
    end else if (m_ok) begin
      if (m_stall) begin
        void'(pend_q.pop_front());
        m_stall <= 0;
      end else if (pend_q.size() != 0) begin
        if (!bus.pipe_we) begin
          void'(pend_q.pop_front());
        end else begin
          m_blocked <= m_blocked + 1;
          if (m_blocked + 1 == MAX_WAIT) m_stall <= 1;
        end
      end else if (bus.mc_valid && bus.mc_addr != 0) begin
        pend_q.push_back('{addr: bus.mc_addr, data: bus.mc_data});
        m_blocked <= 0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              stall;
    logic              ready;
    logic              busy;
    logic [ADDR_W-1:0] baddr;
  } obs_t;

  always @(negedge clk) begin
    obs_t e, a;
    if (m_ok) begin
      e = '0;
      if (pend_q.size() == 0) begin
        e.ready = 1;
        if (bus.pipe_we) begin
          e.we = 1; e.addr = bus.pipe_addr; e.data = bus.pipe_data;
        end
      end else begin
        e.busy  = 1;
        e.baddr = pend_q[0].addr;
        e.stall = m_stall;
        e.we    = 1;
        if (bus.pipe_we && !m_stall) begin
          e.addr = bus.pipe_addr; e.data = bus.pipe_data;
        end else begin
          e.addr = pend_q[0].addr; e.data = pend_q[0].data;
        end
      end
      a = '{we: bus.rf_we, addr: bus.rf_addr, data: bus.rf_data, stall: bus.pipe_stall,
            ready: bus.mc_ready, busy: bus.busy_valid, baddr: bus.busy_addr};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t got=%h expected=%h", $time, a, e);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.pipe_we = we; bus.pipe_addr = a; bus.pipe_data = d;
  endtask

  task automatic set_mc(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.mc_valid = v; bus.mc_addr = a; bus.mc_data = d;
  endtask

  logic [DATA_W-1:0] got_q[$];
  int acc;

  initial begin
    rst = 1;
    set_pipe(0, 0, 0);
    set_mc(0, 0, 0);
    next_cycle();
    next_cycle();

    // reset state
    @(negedge clk);
    chk("rst_ready", bus.mc_ready, 1);
    chk("rst_busy", bus.busy_valid, 0);
    chk("rst_busy_addr", bus.busy_addr, 0);
    chk("rst_stall", bus.pipe_stall, 0);
    chk("rst_rf_we", bus.rf_we, 0);

    // minimum latency: capture with idle pipe, written next cycle
    next_cycle();
    rst = 0;
    set_mc(1, 5, 32'hDEADBEEF);
    @(negedge clk);
    chk("t1_ready", bus.mc_ready, 1);
    next_cycle();
    set_mc(0, 0, 0);
    @(negedge clk);
    chk("t1_we", bus.rf_we, 1);
    chk("t1_addr", bus.rf_addr, 5);
    chk("t1_data", bus.rf_data, 32'hDEADBEEF);
    chk("t1_busy", bus.busy_valid, 1);
    chk("t1_busy_addr", bus.busy_addr, 5);
    next_cycle();
    @(negedge clk);
    chk("t1_idle_busy", bus.busy_valid, 0);
    chk("t1_idle_we", bus.rf_we, 0);

    // forced grant after MAX_WAIT blocked cycles
    next_cycle();
    set_mc(1, 7, 32'h1);
    set_pipe(1, 3, 32'hAA);
    @(negedge clk);
    chk("t2_cap_addr", bus.rf_addr, 3);
    next_cycle();
    set_mc(0, 0, 0);
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      chk("t2_wait_addr", bus.rf_addr, 3);
      chk("t2_wait_ready", bus.mc_ready, 0);
      chk("t2_wait_stall", bus.pipe_stall, 0);
      next_cycle();
    end
    @(negedge clk);
    chk("t2_force_stall", bus.pipe_stall, 1);
    chk("t2_force_addr", bus.rf_addr, 7);
    chk("t2_force_data", bus.rf_data, 32'h1);
    next_cycle();
    @(negedge clk);
    chk("t2_after_stall", bus.pipe_stall, 0);
    chk("t2_after_addr", bus.rf_addr, 3);
    chk("t2_after_data", bus.rf_data, 32'hAA);

    // grant in the first free cycle after two blocked cycles
    next_cycle();
    set_pipe(0, 0, 0);
    set_mc(1, 9, 32'h99);
    next_cycle();
    set_mc(0, 0, 0);
    set_pipe(1, 3, 32'hBB);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t3_block_addr", bus.rf_addr, 3);
      next_cycle();
    end
    set_pipe(0, 0, 0);
    @(negedge clk);
    chk("t3_grant_we", bus.rf_we, 1);
    chk("t3_grant_addr", bus.rf_addr, 9);
    chk("t3_grant_data", bus.rf_data, 32'h99);
    chk("t3_grant_stall", bus.pipe_stall, 0);
    // counter restarts: a fresh result again gets the full MAX_WAIT cycles
    next_cycle();
    set_mc(1, 10, 32'h10);
    next_cycle();
    set_mc(0, 0, 0);
    set_pipe(1, 3, 32'hCC);
    for (int i = 0; i < MAX_WAIT; i++) begin
      @(negedge clk);
      chk("t3_rewait_stall", bus.pipe_stall, 0);
      next_cycle();
    end
    @(negedge clk);
    chk("t3_reforce_stall", bus.pipe_stall, 1);
    chk("t3_reforce_addr", bus.rf_addr, 10);

    // r0 result is accepted and dropped
    next_cycle();
    set_pipe(0, 0, 0);
    set_mc(1, 0, 32'h55);
    @(negedge clk);
    chk("t4_ready", bus.mc_ready, 1);
    chk("t4_we", bus.rf_we, 0);
    next_cycle();
    set_mc(0, 0, 0);
    @(negedge clk);
    chk("t4_we2", bus.rf_we, 0);
    chk("t4_busy", bus.busy_valid, 0);
    chk("t4_ready2", bus.mc_ready, 1);

    // reset while a result is waiting drops it
    next_cycle();
    set_mc(1, 12, 32'hCC);
    set_pipe(1, 3, 32'h33);
    next_cycle();
    set_mc(0, 0, 0);
    rst = 1;
    @(negedge clk);
    chk("t5_busy_before", bus.busy_valid, 1);
    next_cycle();
    rst = 0;
    set_pipe(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_busy", bus.busy_valid, 0);
      chk("t5_we", bus.rf_we, 0);
      chk("t5_stall", bus.pipe_stall, 0);
      chk("t5_ready", bus.mc_ready, 1);
      next_cycle();
    end

    // back-to-back results with idle pipe: accepted every second cycle
    acc = 0;
    got_q.delete();
    for (int c = 0; c < 10; c++) begin
      set_mc(1, 20, 32'h100 + acc);
      @(negedge clk);
      if (bus.rf_we) got_q.push_back(bus.rf_data);
      if (bus.mc_ready) acc++;
      next_cycle();
    end
    set_mc(0, 0, 0);
    @(negedge clk);
    if (bus.rf_we) got_q.push_back(bus.rf_data);
    chk("t6_accepted", acc, 5);
    chk("t6_writes", got_q.size(), 5);
    for (int i = 0; i < got_q.size(); i++) chk("t6_order", got_q[i], 32'h100 + i);

    // randomized traffic, pipeline busier in some phases to provoke forcing
    for (int c = 0; c < 4000; c++) begin
      int pw_pct;
      next_cycle();
      pw_pct = (c < 1500) ? 50 : ((c < 3000) ? 90 : 20);
      rst = ($urandom_range(0, 299) == 0);
      set_pipe($urandom_range(0, 99) < pw_pct, ADDR_W'($urandom), $urandom);
      set_mc($urandom_range(0, 1) == 1,
             ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom), $urandom);
    end
    next_cycle();
    rst = 0;
    set_pipe(0, 0, 0);
    set_mc(0, 0, 0);
    repeat (MAX_WAIT + 3) next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
